// File: rtl/bcd_scan_display_if.sv
// bcd_scan_display_if: capture/control inputs and multiplexed display outputs of the BCD scanner
interface bcd_scan_display_if #(parameter int NUM_DIGITS = 4);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    blank_lz;
  logic                    err_clr;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    err;
  modport master (output load, bcd_in, blank_lz, err_clr, input seg, an, err);
  modport slave (input load, bcd_in, blank_lz, err_clr, output seg, an, err);
endinterface

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: captures packed BCD digits and scans them onto a shared seven-segment bus
module bcd_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  bcd_scan_display_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [NUM_DIGITS-1:0][3:0] r_dig;
  logic [CW-1:0]              r_cnt;
  logic [IW-1:0]              r_idx;
  logic [6:0]                 r_seg;
  logic [NUM_DIGITS-1:0]      r_an;
  logic                       r_err;
  logic [NUM_DIGITS-1:0]      w_lz;
  logic                       w_run;
  logic                       w_bad;
  logic                       w_wrap;
  logic [3:0]                 w_cur;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'h3F;
      4'd1: enc = 7'h06;
      4'd2: enc = 7'h5B;
      4'd3: enc = 7'h4F;
      4'd4: enc = 7'h66;
      4'd5: enc = 7'h6D;
      4'd6: enc = 7'h7D;
      4'd7: enc = 7'h07;
      4'd8: enc = 7'h7F;
      4'd9: enc = 7'h6F;
      default: enc = 7'h40;
    endcase
  endfunction

  // A digit is blanked while it and everything above it is zero; invalid nibbles are nonzero so they stop it
  always_comb begin
    w_lz  = '0;
    w_run = bus.blank_lz;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_run   = w_run && (r_dig[i] == 4'd0);
      w_lz[i] = w_run;
    end
  end

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      w_bad = w_bad || (bus.bcd_in[4*i +: 4] > 4'd9);
  end

  assign w_wrap = r_cnt == CW'(SCAN_DIV - 1);
  assign w_cur  = r_dig[r_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dig <= '0;
      r_cnt <= '0;
      r_idx <= '0;
      r_seg <= 7'h00;
      r_an  <= '0;
      r_err <= 1'b0;
    end else begin
      if (bus.load) r_dig <= bus.bcd_in;
      r_err <= (bus.load && w_bad) ? 1'b1 : bus.err_clr ? 1'b0 : r_err;
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      r_an  <= w_wrap ? '0 : NUM_DIGITS'(1) << r_idx;
      r_seg <= (w_wrap || w_lz[r_idx]) ? 7'h00 : enc(w_cur);
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.err = r_err;
endmodule
